// File: rtl/seven_seg_scanner.sv
// Scan controller for a common-anode multiplexed seven-segment display.
// Each digit gets a dark BLANK slot and then a SHOW slot. A new value is only committed at the end of a frame.
module seven_seg_scanner #(
    parameter int DIGITS = 4,
    parameter int DWELL  = 1000,
    parameter int BLANK  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  load,
    input  logic                  lz_blank,
    output logic [3:0]            nibble_out,
    output logic [DIGITS-1:0]     digit_en_n,
    output logic                  frame_done
);

    localparam int PMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam int IW   = $clog2(DIGITS);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    typedef enum logic {S_BLANK, S_SHOW} state_t;

    state_t                  state, state_d;
    logic [CW-1:0]           phase_cnt, phase_cnt_d;
    logic [IW-1:0]           idx, idx_d;
    logic [DIGITS-1:0][3:0]  shadow, shadow_d, pend_val;
    logic                    pend;
    logic [DIGITS-1:0]       upper_zero;
    logic [DIGITS-1:0]       en_d;
    logic                    last_show;
    logic                    run;

    // The state register runs one cycle ahead of the output flops, which decode it.
    always_comb begin
        state_d     = state;
        phase_cnt_d = phase_cnt + 1'b1;
        idx_d       = idx;
        case (state)
            S_BLANK: if (phase_cnt == BLANK_LAST) begin
                state_d     = S_SHOW;
                phase_cnt_d = '0;
            end
            S_SHOW: if (phase_cnt == DWELL_LAST) begin
                state_d     = S_BLANK;
                phase_cnt_d = '0;
                idx_d       = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            default: state_d = S_BLANK;
        endcase
    end

    assign last_show = (state == S_SHOW) && (phase_cnt == DWELL_LAST) && (idx == IDX_LAST);

    // A commit happens while frame_done is high. A coincident load overrides the pending value.
    always_comb begin
        shadow_d = shadow;
        if (frame_done) begin
            if (load)
                shadow_d = value_in;
            else if (pend)
                shadow_d = pend_val;
        end
    end

    always_comb begin
        upper_zero = '0;
        run        = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run           = run && (shadow_d[i] == 4'h0);
            upper_zero[i] = run;
        end
        en_d = '1;
        if (state == S_SHOW && !(lz_blank && idx != '0 && upper_zero[idx]))
            en_d[idx] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_BLANK;
            phase_cnt  <= '0;
            idx        <= '0;
            shadow     <= '0;
            pend_val   <= '0;
            pend       <= 1'b0;
            nibble_out <= 4'h0;
            digit_en_n <= '1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            phase_cnt  <= phase_cnt_d;
            idx        <= idx_d;
            shadow     <= shadow_d;
            if (frame_done) begin
                pend <= 1'b0;
            end else if (load) begin
                pend     <= 1'b1;
                pend_val <= value_in;
            end
            nibble_out <= shadow_d[idx];
            digit_en_n <= en_d;
            frame_done <= last_show;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with DIGITS=4, DWELL=4, BLANK=2, which gives a 24-cycle frame.
// It walks frames cycle by cycle against hand-derived slot expectations.
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic        load;
    logic        lz_blank;
    logic [3:0]  nibble_out;
    logic [3:0]  digit_en_n;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;

    seven_seg_scanner #(.DIGITS(4), .DWELL(4), .BLANK(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .load       (load),
        .lz_blank   (lz_blank),
        .nibble_out (nibble_out),
        .digit_en_n (digit_en_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps n cycles. The walk starts at a frame_done cycle, or on the cycle after reset is released.
    // Every cycle of the frame is compared against the slot layout for the value 'val'.
    // Loads of va/vb are issued after the checks of steps la/lb.
    task automatic check_frame(input logic [15:0] val, input int n,
                               input int la, input logic [15:0] va,
                               input int lb, input logic [15:0] vb);
        int         d, p;
        logic [3:0] exp_en;
        logic [3:0] exp_nib;
        logic       sup;
        for (int k = 1; k <= n; k++) begin
            step();
            load    = 1'b0;
            d       = (k - 1) / 6;
            p       = (k - 1) % 6;
            exp_nib = 4'((val >> (4 * d)) & 16'hF);
            sup     = lz_blank && (d != 0) && ((val >> (4 * d)) == 16'h0);
            exp_en  = 4'hF;
            if (p >= 2 && !sup)
                exp_en[d] = 1'b0;
            check($sformatf("en v=%h k=%0d", val, k), 32'(digit_en_n), 32'(exp_en));
            check($sformatf("nib v=%h k=%0d", val, k), 32'(nibble_out), 32'(exp_nib));
            check($sformatf("fd v=%h k=%0d", val, k), 32'(frame_done), 32'(p == 5 && d == 3));
            if (k == la) begin load = 1'b1; value_in = va; end
            if (k == lb) begin load = 1'b1; value_in = vb; end
        end
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        value_in = 16'h0;
        lz_blank = 1'b0;

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_en", 32'(digit_en_n), 32'hF);
            check("rst_nib", 32'(nibble_out), 32'h0);
            check("rst_fd", 32'(frame_done), 32'h0);
        end
        rst = 1'b0;

        // First frame shows 0000. A load issued mid-frame stays pending until the frame boundary.
        check_frame(16'h0000, 24, 10, 16'h1A2F, -1, 16'h0);
        check_frame(16'h1A2F, 24, -1, 16'h0, -1, 16'h0);
        check_frame(16'h1A2F, 24, -1, 16'h0, -1, 16'h0);

        // Tear-free: a load during digit 1 leaves the rest of the frame untouched.
        load = 1'b1; value_in = 16'h1234;
        check_frame(16'h1234, 24, 8, 16'hABCD, -1, 16'h0);

        // Last wins.
        check_frame(16'hABCD, 24, 3, 16'h1111, 15, 16'h2222);

        // A coincident load overrides the pending 1111 and clears the pend flag.
        check_frame(16'h2222, 24, 5, 16'h1111, -1, 16'h0);
        load = 1'b1; value_in = 16'h5555;
        check_frame(16'h5555, 24, -1, 16'h0, -1, 16'h0);
        check_frame(16'h5555, 24, -1, 16'h0, -1, 16'h0);

        // Leading-zero blanking.
        lz_blank = 1'b1;
        load = 1'b1; value_in = 16'h00A0;
        check_frame(16'h00A0, 24, -1, 16'h0, -1, 16'h0);
        load = 1'b1; value_in = 16'h0000;
        check_frame(16'h0000, 24, -1, 16'h0, -1, 16'h0);
        lz_blank = 1'b0;

        // Reset asserted during the digit 2 SHOW slot while 1234 is pending.
        load = 1'b1; value_in = 16'hBEEF;
        check_frame(16'hBEEF, 15, 3, 16'h1234, -1, 16'h0);
        rst = 1'b1;
        step();
        check("mid_rst_en", 32'(digit_en_n), 32'hF);
        check("mid_rst_nib", 32'(nibble_out), 32'h0);
        check("mid_rst_fd", 32'(frame_done), 32'h0);
        load = 1'b1; value_in = 16'h1234;
        step();
        check("rst_load_en", 32'(digit_en_n), 32'hF);
        check("rst_load_nib", 32'(nibble_out), 32'h0);
        rst  = 1'b0;
        load = 1'b0;
        check_frame(16'h0000, 24, -1, 16'h0, -1, 16'h0);
        check_frame(16'h0000, 24, -1, 16'h0, -1, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
